// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and defaults for the branch controller
package branch_pkg;

  localparam int DEFAULT_PC_WIDTH    = 8;
  localparam int DEFAULT_COUNT_WIDTH = 8;

  // Condition codes as presented by the instruction decoder
  typedef enum logic [2:0] {
    NOP = 3'b000,
    JMP = 3'b001,
    BEQ = 3'b010,
    BNE = 3'b011,
    BGT = 3'b100,
    BGE = 3'b101,
    BLT = 3'b110,
    BLE = 3'b111
  } branch_op_t;

  // HOLD is the single stall cycle spent waiting for a flag rewrite to land
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/branch_control_if.sv
// rtl/branch_control_if.sv - decoder/fetch side signals of the branch controller
interface branch_control_if
  import branch_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
);

  logic                   flag_Z;
  logic                   flag_N;
  logic                   status_wr;
  logic                   pc_wr;
  logic                   branch_valid;
  branch_op_t             branch_op;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [PC_WIDTH-1:0]    pc_out;
  logic                   branch_taken;
  logic                   branch_busy;
  logic [COUNT_WIDTH-1:0] taken_count;

  // Decoder / status register side
  modport master (
    output flag_Z, flag_N, status_wr, pc_wr, branch_valid, branch_op, branch_target,
    input  pc_out, branch_taken, branch_busy, taken_count
  );

  // Branch controller side
  modport slave (
    input  flag_Z, flag_N, status_wr, pc_wr, branch_valid, branch_op, branch_target,
    output pc_out, branch_taken, branch_busy, taken_count
  );

endinterface

// File: rtl/branch_condition.sv
// rtl/branch_condition.sv - combinational condition evaluation from Z/N flags
module branch_condition
  import branch_pkg::*;
(
  input  branch_op_t op,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       taken
);

  // Decode the condition code against the current flags
  always_comb begin
    taken = 1'b0;
    case (op)
      NOP:     taken = 1'b0;
      JMP:     taken = 1'b1;
      BEQ:     taken = flag_z;
      BNE:     taken = !flag_z;
      BGT:     taken = !flag_z && !flag_n;
      BGE:     taken = !flag_n;
      BLT:     taken = flag_n;
      BLE:     taken = flag_z || flag_n;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_control.sv
// rtl/branch_control.sv - program counter with flag-hazard-aware branch resolution
module branch_control
  import branch_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic              clock,
  input  logic              branch_reset,
  branch_control_if.slave   bus
);

  state_t                 state_q, state_d;
  branch_op_t             op_q, op_d;
  logic [PC_WIDTH-1:0]    target_q, target_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   taken_q, taken_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  branch_op_t          resolve_op;
  logic [PC_WIDTH-1:0] resolve_target;
  logic                resolve;
  logic                cond_taken;

  // In HOLD the latched branch is resolved; otherwise the one on the bus
  assign resolve_op     = (state_q == HOLD) ? op_q     : bus.branch_op;
  assign resolve_target = (state_q == HOLD) ? target_q : bus.branch_target;

  branch_condition u_cond (
    .op     (resolve_op),
    .flag_z (bus.flag_Z),
    .flag_n (bus.flag_N),
    .taken  (cond_taken)
  );

  // Next-state, PC and counter update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    target_d = target_q;
    pc_d     = pc_q;
    taken_d  = 1'b0;
    count_d  = count_q;
    resolve  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.branch_valid) begin
          if (bus.status_wr) begin
            // Flags are changing under us: park the branch for one cycle
            op_d     = bus.branch_op;
            target_d = bus.branch_target;
            state_d  = HOLD;
          end else begin
            resolve = 1'b1;
          end
        end else if (bus.pc_wr) begin
          pc_d = pc_q + 1'b1;
        end
      end
      HOLD: begin
        resolve = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (resolve) begin
      if (cond_taken) begin
        pc_d    = resolve_target;
        taken_d = 1'b1;
        if (count_q != '1) count_d = count_q + 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge branch_reset) begin
    if (branch_reset) begin
      state_q  <= IDLE;
      op_q     <= NOP;
      target_q <= '0;
      pc_q     <= '0;
      taken_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      target_q <= target_d;
      pc_q     <= pc_d;
      taken_q  <= taken_d;
      count_q  <= count_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.branch_taken = taken_q;
  assign bus.branch_busy  = (state_q == HOLD);
  assign bus.taken_count  = count_q;

endmodule

// File: tb/tb_branch_control.sv
// tb/tb_branch_control.sv - directed table-driven bench for branch_control
module tb_branch_control;
  import branch_pkg::*;

  logic clock;
  logic branch_reset;

  branch_control_if #(.PC_WIDTH(8), .COUNT_WIDTH(8)) bus ();
  branch_control_if #(.PC_WIDTH(8), .COUNT_WIDTH(2)) bus2 ();

  branch_control #(.PC_WIDTH(8), .COUNT_WIDTH(8)) dut (
    .clock        (clock),
    .branch_reset (branch_reset),
    .bus          (bus)
  );

  branch_control #(.PC_WIDTH(8), .COUNT_WIDTH(2)) dut_sat (
    .clock        (clock),
    .branch_reset (branch_reset),
    .bus          (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    branch_op_t op;
    logic [3:0] exp;   // expected taken, indexed by {Z,N}
  } vec_t;

  vec_t tbl [8];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flag_Z = 0; bus.flag_N = 0; bus.status_wr = 0; bus.pc_wr = 0;
    bus.branch_valid = 0; bus.branch_op = NOP; bus.branch_target = '0;
    bus2.flag_Z = 0; bus2.flag_N = 0; bus2.status_wr = 0; bus2.pc_wr = 0;
    bus2.branch_valid = 0; bus2.branch_op = NOP; bus2.branch_target = '0;
  endtask

  initial begin
    logic [7:0] pc_m;
    logic [7:0] cnt_m;
    logic [7:0] tgt;
    logic       e;

    tbl[0] = '{op: NOP, exp: 4'b0000};
    tbl[1] = '{op: JMP, exp: 4'b1111};
    tbl[2] = '{op: BEQ, exp: 4'b1100};
    tbl[3] = '{op: BNE, exp: 4'b0011};
    tbl[4] = '{op: BGT, exp: 4'b0001};
    tbl[5] = '{op: BGE, exp: 4'b0101};
    tbl[6] = '{op: BLT, exp: 4'b1010};
    tbl[7] = '{op: BLE, exp: 4'b1110};

    idle_inputs();
    branch_reset = 1'b1;
    #12;
    check("reset pc", bus.pc_out, 0);
    check("reset taken", bus.branch_taken, 0);
    check("reset busy", bus.branch_busy, 0);
    check("reset count", bus.taken_count, 0);
    branch_reset = 1'b0;

    // 1: sequential advance
    bus.pc_wr = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("seq pc", bus.pc_out, k);
      check("seq taken", bus.branch_taken, 0);
    end
    bus.pc_wr = 0;
    check("seq count", bus.taken_count, 0);

    // 2: unstalled BEQ taken, BNE not taken
    bus.flag_Z = 1; bus.flag_N = 0;
    bus.branch_valid = 1; bus.branch_op = BEQ; bus.branch_target = 8'h40;
    step();
    check("beq pc", bus.pc_out, 8'h40);
    check("beq taken", bus.branch_taken, 1);
    check("beq count", bus.taken_count, 1);
    bus.branch_op = BNE; bus.branch_target = 8'h99;
    step();
    check("bne pc", bus.pc_out, 8'h41);
    check("bne taken", bus.branch_taken, 0);
    bus.branch_valid = 0;
    step();
    check("after bne pc", bus.pc_out, 8'h41);
    check("after bne count", bus.taken_count, 1);

    // 3: branch during status write stalls and sees the new Z
    bus.flag_Z = 0;
    bus.branch_valid = 1; bus.branch_op = BEQ; bus.branch_target = 8'h20;
    bus.status_wr = 1;
    step();
    check("stall busy", bus.branch_busy, 1);
    check("stall pc", bus.pc_out, 8'h41);
    check("stall taken", bus.branch_taken, 0);
    bus.status_wr = 0; bus.flag_Z = 1; bus.branch_valid = 0; bus.pc_wr = 1;
    step();
    check("post stall pc", bus.pc_out, 8'h20);
    check("post stall taken", bus.branch_taken, 1);
    check("post stall busy", bus.branch_busy, 0);
    check("post stall count", bus.taken_count, 2);
    bus.pc_wr = 0;
    step();
    check("pulse one cycle", bus.branch_taken, 0);
    pc_m = 8'h20; cnt_m = 8'd2;

    // 4: every op against every flag combination, back-to-back
    bus.branch_valid = 1;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) begin
        bus.flag_Z = c[1]; bus.flag_N = c[0];
        tgt = 8'h80 + 8'(i * 4 + c);
        bus.branch_op = tbl[i].op; bus.branch_target = tgt;
        e = tbl[i].exp[c];
        step();
        pc_m = e ? tgt : pc_m + 8'd1;
        cnt_m = cnt_m + {7'd0, e};
        check($sformatf("sweep op%0d zn%0d taken", i, c), bus.branch_taken, {31'd0, e});
        check($sformatf("sweep op%0d zn%0d pc", i, c), bus.pc_out, pc_m);
      end
    end
    check("sweep count", bus.taken_count, cnt_m);

    // 5: PC wrap, then 2-bit counter saturation
    bus.branch_op = JMP; bus.branch_target = 8'hFF;
    step();
    check("jmp ff pc", bus.pc_out, 8'hFF);
    bus.branch_valid = 0; bus.pc_wr = 1;
    step();
    check("wrap pc", bus.pc_out, 8'h00);
    bus.pc_wr = 0;

    bus2.branch_valid = 1; bus2.branch_op = JMP;
    for (int k = 1; k <= 5; k++) begin
      bus2.branch_target = 8'h10 + 8'(k);
      step();
      check("sat count", bus2.taken_count, (k > 3) ? 3 : k);
      check("sat pc", bus2.pc_out, 8'h10 + k);
    end
    bus2.branch_valid = 0;

    // 6: reset in the middle of a stall discards the branch
    bus.branch_valid = 1; bus.branch_op = JMP; bus.branch_target = 8'h77;
    bus.status_wr = 1;
    step();
    check("pre reset busy", bus.branch_busy, 1);
    idle_inputs();
    #2 branch_reset = 1'b1;
    #1;
    check("mid hold reset pc", bus.pc_out, 0);
    check("mid hold reset busy", bus.branch_busy, 0);
    #3 branch_reset = 1'b0;
    step();
    check("post reset pc", bus.pc_out, 0);
    check("post reset taken", bus.branch_taken, 0);
    check("post reset count", bus.taken_count, 0);
    check("post reset busy", bus.branch_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
